// File: rtl/din_pattern_loader_if.sv
// ---------------------------------------------------------------------------
// din_pattern_loader_if
//   Host-side byte stream and control bus of the DIN pattern loader.
//
//   wr_data  : host data word
//   wr_valid : wr_data is valid
//   wr_last  : final word of a frame (qualified by wr_valid)
//   wr_ready : loader can accept a word
//   commit   : single-cycle request to launch the loaded frame
//   abort    : synchronous cancel back to the load state
//
//   master : host side (drives data and control)
//   slave  : loader side (drives wr_ready)
// ---------------------------------------------------------------------------
interface din_pattern_loader_if #(
    parameter int WORD_W = 8
) ();

    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_last;
    logic              wr_ready;
    logic              commit;
    logic              abort;

    modport master (
        output wr_data,
        output wr_valid,
        output wr_last,
        output commit,
        output abort,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  wr_last,
        input  commit,
        input  abort,
        output wr_ready
    );

endinterface

// File: rtl/din_pattern_loader.sv
// ---------------------------------------------------------------------------
// din_pattern_loader
//   Upstream stage of the DIN/SYN/CLK serializer. Assembles a frame of host
//   words into a shadow register, copies it into data_reg on commit, issues a
//   fixed-width trigger pulse and then tracks the serializer's busy window so
//   a pattern is never re-triggered or overwritten mid-transfer.
//
//   clk_in      : system clock, all logic on posedge
//   rst_n       : asynchronous active-low reset
//   host        : host byte stream / commit / abort (slave modport)
//   busy        : serializer out_en | clk_out_en, same clock domain
//   data_reg    : pattern to serializer, bit 0 is sent first
//   trig        : trigger pulse to serializer (TRIG_LEN cycles)
//   word_cnt    : words accepted in the current frame
//   done        : one-cycle pulse when the serializer finishes
//   frame_err   : sticky, wr_last arrived before the frame was complete
//   timeout_err : sticky, busy never rose after the trigger
// ---------------------------------------------------------------------------
module din_pattern_loader #(
    parameter int TOTAL_BITS    = 491,
    parameter int WORD_W        = 8,
    parameter int N_WORDS       = 62,
    parameter int TRIG_LEN      = 4,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    din_pattern_loader_if.slave   host,
    input  logic                  busy,
    output logic [TOTAL_BITS-1:0] data_reg,
    output logic                  trig,
    output logic [5:0]            word_cnt,
    output logic                  done,
    output logic                  frame_err,
    output logic                  timeout_err
);

    // One counter serves both as the trigger-width counter in FIRE and as the
    // start timeout timer in WAIT_START; it is cleared on each state entry.
    localparam int TMR_W = $clog2(START_TIMEOUT);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FULL,
        ST_FIRE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
    logic [TOTAL_BITS-1:0] data_reg_q, data_reg_d;
    logic [5:0]            word_cnt_q, word_cnt_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  pending_q, pending_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  accept;

    // Ready is forced low while reset is held, then follows the LOAD state.
    assign host.wr_ready = rst_n && (state_q == ST_LOAD);
    assign accept        = host.wr_valid && host.wr_ready;

    // NOTE: every variable gets its hold/default value before any branch so
    // no path through this block can infer a latch.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        data_reg_d    = data_reg_q;
        word_cnt_d    = word_cnt_q;
        timer_d       = timer_q;
        pending_d     = pending_q;
        trig_d        = 1'b0;
        done_d        = 1'b0;
        frame_err_d   = frame_err_q;
        timeout_err_d = timeout_err_q;

        if (host.abort) begin
            // Abort outranks every other event; data_reg is deliberately kept.
            state_d    = ST_LOAD;
            word_cnt_d = '0;
            timer_d    = '0;
            pending_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    // commit is ignored here, including when it coincides
                    // with an accepted word.
                    if (accept) begin
                        // Word k lands in bits [WORD_W*k +: WORD_W]; bits of
                        // the last word beyond TOTAL_BITS have no home.
                        for (int i = 0; i < TOTAL_BITS; i++) begin
                            if ((i / WORD_W) == int'(word_cnt_q)) begin
                                shadow_d[i] = host.wr_data[i % WORD_W];
                            end
                        end
                        if (word_cnt_q == 6'(N_WORDS - 1)) begin
                            word_cnt_d = 6'(N_WORDS);
                            state_d    = ST_FULL;
                        end else if (host.wr_last) begin
                            // Short frame: flag it and restart; the partial
                            // shadow is simply overwritten by the next frame.
                            frame_err_d = 1'b1;
                            word_cnt_d  = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + 6'd1;
                        end
                    end
                end

                ST_FULL: begin
                    // A commit seen while the serializer is still busy is
                    // remembered and fires as soon as busy drops.
                    if (host.commit || pending_q) begin
                        if (!busy) begin
                            data_reg_d = shadow_q;
                            pending_d  = 1'b0;
                            timer_d    = '0;
                            state_d    = ST_FIRE;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                end

                ST_FIRE: begin
                    // The entry cycle is spent with trig low so data_reg is
                    // settled one cycle before the pulse starts.
                    if (timer_q < TMR_W'(TRIG_LEN)) begin
                        trig_d  = 1'b1;
                        timer_d = timer_q + 1'b1;
                    end else begin
                        timer_d = '0;
                        state_d = ST_WAIT_START;
                    end
                end

                ST_WAIT_START: begin
                    if (busy) begin
                        timer_d = '0;
                        state_d = ST_WAIT_DONE;
                    end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        word_cnt_d    = '0;
                        timer_d       = '0;
                        state_d       = ST_LOAD;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!busy) begin
                        done_d     = 1'b1;
                        word_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end

                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    // NOTE: the wide shadow and data_reg are plain registers (not RAM) and
    // are reset so the serializer never sees an undefined pattern.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            shadow_q      <= '0;
            data_reg_q    <= '0;
            word_cnt_q    <= '0;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            trig_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            data_reg_q    <= data_reg_d;
            word_cnt_q    <= word_cnt_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            trig_q        <= trig_d;
            done_q        <= done_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign data_reg    = data_reg_q;
    assign trig        = trig_q;
    assign word_cnt    = word_cnt_q;
    assign done        = done_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_din_pattern_loader.sv
// ---------------------------------------------------------------------------
// tb_din_pattern_loader
//   Directed sequence with randomized frame contents and busy timing. The
//   expected pattern is built from the frame bytes by shifting them into a
//   wide accumulator; timing expectations come from the documented latencies.
// ---------------------------------------------------------------------------
module tb_din_pattern_loader;

    localparam int TOTAL_BITS    = 491;
    localparam int WORD_W        = 8;
    localparam int N_WORDS       = 62;
    localparam int TRIG_LEN      = 4;
    localparam int START_TIMEOUT = 1024;

    logic                  clk_in = 1'b0;
    logic                  rst_n  = 1'b0;
    logic                  busy   = 1'b0;
    logic [TOTAL_BITS-1:0] data_reg;
    logic                  trig;
    logic [5:0]            word_cnt;
    logic                  done;
    logic                  frame_err;
    logic                  timeout_err;

    din_pattern_loader_if #(.WORD_W(WORD_W)) dif ();

    din_pattern_loader #(
        .TOTAL_BITS   (TOTAL_BITS),
        .WORD_W       (WORD_W),
        .N_WORDS      (N_WORDS),
        .TRIG_LEN     (TRIG_LEN),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .host       (dif),
        .busy       (busy),
        .data_reg   (data_reg),
        .trig       (trig),
        .word_cnt   (word_cnt),
        .done       (done),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]            frame [N_WORDS];
    logic [TOTAL_BITS-1:0] exp_a, exp_b, exp_c;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each posedge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference packing: byte k occupies bits 8k+7..8k, then truncate.
    function automatic logic [TOTAL_BITS-1:0] pack_frame();
        logic [N_WORDS*WORD_W-1:0] acc;
        acc = '0;
        for (int k = N_WORDS - 1; k >= 0; k--) begin
            acc = (acc << WORD_W) | (N_WORDS*WORD_W)'(frame[k]);
        end
        return acc[TOTAL_BITS-1:0];
    endfunction

    task automatic random_frame();
        for (int k = 0; k < N_WORDS; k++) frame[k] = 8'($urandom);
    endtask

    task automatic send_words(input int n, input int last_idx);
        for (int k = 0; k < n; k++) begin
            dif.wr_valid = 1'b1;
            dif.wr_data  = frame[k];
            dif.wr_last  = (k == last_idx);
            tick();
        end
        dif.wr_valid = 1'b0;
        dif.wr_last  = 1'b0;
    endtask

    task automatic commit_pulse();
        dif.commit = 1'b1;
        tick();
        dif.commit = 1'b0;
    endtask

    // Ticks until trig is seen high, then counts consecutive high samples.
    task automatic measure_trig(output int delay, output int width);
        delay = 0;
        while (trig !== 1'b1 && delay < 40) begin
            tick();
            delay++;
        end
        width = 0;
        while (trig === 1'b1 && width < 40) begin
            tick();
            width++;
        end
    endtask

    initial begin
        int d, w, seen_trig, seen_done;

        dif.wr_data  = '0;
        dif.wr_valid = 1'b0;
        dif.wr_last  = 1'b0;
        dif.commit   = 1'b0;
        dif.abort    = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) tick();
        check("rst_wr_ready", dif.wr_ready, 0);
        check("rst_data_reg", data_reg, 0);
        check("rst_trig", trig, 0);
        check("rst_done", done, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();
        check("load_wr_ready", dif.wr_ready, 1);

        // ---------------- counting frame, commit with busy low ----------------
        for (int k = 0; k < N_WORDS; k++) frame[k] = 8'(k);
        exp_a = pack_frame();
        send_words(N_WORDS, N_WORDS - 1);
        check("t1_word_cnt_full", word_cnt, 62);
        check("t1_wr_ready_full", dif.wr_ready, 0);
        commit_pulse();
        check("t1_data_reg", data_reg, exp_a);
        check("t1_data_lsb", data_reg[7:0], 8'h00);
        check("t1_data_msb", data_reg[490:488], 3'h5);
        check("t1_trig_entry", trig, 0);
        measure_trig(d, w);
        check("t1_trig_delay", d, 1);
        check("t1_trig_width", w, TRIG_LEN);

        // ---------------- busy window of 500 cycles ----------------
        repeat ($urandom_range(0, 50)) tick();
        busy = 1'b1;
        seen_done = 0;
        repeat (500) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        busy = 1'b0;
        tick();
        check("t2_done_pulse", done, 1);
        check("t2_word_cnt", word_cnt, 0);
        check("t2_back_in_load", dif.wr_ready, 1);
        check("t2_data_kept", data_reg, exp_a);
        repeat (3) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        check("t2_extra_done", seen_done, 0);

        // ---------------- short frame then a good frame ----------------
        random_frame();
        send_words(11, 10);
        check("t3_frame_err", frame_err, 1);
        check("t3_word_cnt", word_cnt, 0);
        check("t3_wr_ready", dif.wr_ready, 1);
        random_frame();
        exp_b = pack_frame();
        send_words(N_WORDS, N_WORDS - 1);
        check("t3_word_cnt_full", word_cnt, 62);
        check("t3_frame_err_sticky", frame_err, 1);

        // ---------------- commit while busy ----------------
        busy = 1'b1;
        tick();
        commit_pulse();
        seen_trig = 0;
        repeat (20) begin
            tick();
            if (trig === 1'b1) seen_trig++;
        end
        check("t4_no_trig_busy", seen_trig, 0);
        check("t4_data_held", data_reg, exp_a);
        check("t4_still_full", dif.wr_ready, 0);
        busy = 1'b0;
        measure_trig(d, w);
        check("t4_trig_delay", d, 2);
        check("t4_trig_width", w, TRIG_LEN);
        check("t4_data_new", data_reg, exp_b);
        repeat ($urandom_range(0, 20)) tick();
        busy = 1'b1;
        repeat ($urandom_range(5, 40)) tick();
        busy = 1'b0;
        tick();
        check("t4_done_pulse", done, 1);

        // ---------------- start timeout ----------------
        random_frame();
        exp_c = pack_frame();
        send_words(N_WORDS, N_WORDS - 1);
        commit_pulse();
        measure_trig(d, w);
        check("t5_trig_width", w, TRIG_LEN);
        repeat (START_TIMEOUT - 1) tick();
        check("t5_no_err_yet", timeout_err, 0);
        check("t5_still_waiting", dif.wr_ready, 0);
        tick();
        check("t5_timeout_err", timeout_err, 1);
        check("t5_back_in_load", dif.wr_ready, 1);
        check("t5_word_cnt", word_cnt, 0);
        check("t5_no_done", done, 0);

        // ---------------- abort during FIRE ----------------
        random_frame();
        exp_a = pack_frame();
        send_words(N_WORDS, N_WORDS - 1);
        commit_pulse();
        check("t6_data_fire", data_reg, exp_a);
        tick();
        check("t6_trig_high", trig, 1);
        dif.abort = 1'b1;
        tick();
        dif.abort = 1'b0;
        check("t6_abort_trig", trig, 0);
        check("t6_abort_word_cnt", word_cnt, 0);
        check("t6_abort_load", dif.wr_ready, 1);
        check("t6_abort_data_kept", data_reg, exp_a);
        seen_trig = 0;
        seen_done = 0;
        repeat (8) begin
            tick();
            if (trig === 1'b1) seen_trig++;
            if (done === 1'b1) seen_done++;
        end
        check("t6_no_trig_after", seen_trig, 0);
        check("t6_no_done_after", seen_done, 0);

        // word and commit together in LOAD: word taken, commit dropped
        dif.wr_valid = 1'b1;
        dif.wr_data  = 8'($urandom);
        dif.commit   = 1'b1;
        tick();
        dif.wr_valid = 1'b0;
        dif.commit   = 1'b0;
        check("t7_word_taken", word_cnt, 1);
        repeat (4) tick();
        check("t7_commit_dropped", trig, 0);
        check("t7_still_load", dif.wr_ready, 1);
        // abort outranks a simultaneous word
        dif.abort    = 1'b1;
        dif.wr_valid = 1'b1;
        tick();
        dif.abort    = 1'b0;
        dif.wr_valid = 1'b0;
        check("t7_abort_prio", word_cnt, 0);

        // ---------------- reset during WAIT_DONE ----------------
        random_frame();
        send_words(N_WORDS, N_WORDS - 1);
        commit_pulse();
        measure_trig(d, w);
        busy = 1'b1;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_data", data_reg, 0);
        check("t8_rst_word_cnt", word_cnt, 0);
        check("t8_rst_trig", trig, 0);
        check("t8_rst_wr_ready", dif.wr_ready, 0);
        check("t8_rst_frame_err", frame_err, 0);
        check("t8_rst_timeout_err", timeout_err, 0);
        tick();
        busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t8_no_done", done, 0);
        check("t8_load_after", dif.wr_ready, 1);

        // ---------------- reset drops trig asynchronously ----------------
        random_frame();
        send_words(N_WORDS, N_WORDS - 1);
        commit_pulse();
        tick();
        check("t9_trig_high", trig, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t9_async_trig", trig, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/din_pattern_loader.md
Name: din_pattern_loader

Overview:
- Upstream stage of the DIN/SYN/CLK serializer.
- Accepts the control pattern as a stream of bytes from the virtual-JTAG host interface and assembles them into a shadow register.
- On host commit, copies the shadow into the serializer's 491-bit data_reg and issues a clean trigger pulse.
- Tracks the serializer's busy window so a pattern is never re-triggered or overwritten mid-transfer.

Parameters:
- TOTAL_BITS, 491, pattern length in bits; equals the serializer data_reg width.
- WORD_W, 8, host word width.
- N_WORDS, 62, words per frame, ceil(TOTAL_BITS/WORD_W).
- TRIG_LEN, 4, trigger pulse width in clk_in cycles.
- START_TIMEOUT, 1024, cycles allowed for busy to rise after trigger.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_data  input  WORD_W  host data word.
- wr_valid  input  1  wr_data valid.
- wr_last  input  1  marks final word of frame; qualified by wr_valid.
- wr_ready  output  1  loader can accept a word.
- commit  input  1  single-cycle request to launch the loaded frame.
- abort  input  1  synchronous cancel, returns to LOAD.
- busy  input  1  serializer out_en OR clk_out_en; same clock domain.
- data_reg  output  TOTAL_BITS  pattern to serializer.
- trig  output  1  trigger to serializer.
- word_cnt  output  6  words accepted in current frame.
- done  output  1  one-cycle pulse when serializer finishes.
- frame_err  output  1  sticky: wr_last arrived early.
- timeout_err  output  1  sticky: busy never rose after trigger.

Behaviour:
- Reset values: data_reg=0, shadow=0, trig=0, done=0, word_cnt=0, frame_err=0, timeout_err=0, state=LOAD. wr_ready=0 while rst_n low, then 1 in LOAD.
- Transfer: a word is accepted when wr_valid & wr_ready on a posedge.
- Packing: word k is written to shadow[WORD_W*k+WORD_W-1 : WORD_W*k], LSB = lowest bit index. Bits at index >= TOTAL_BITS in word 61 are discarded. Serializer sends data_reg[0] first.
- LOAD state:
  - wr_ready=1; each accepted word increments word_cnt.
  - Accepting word N_WORDS-1 moves to FULL with word_cnt=62.
  - wr_last on an accepted word with word_cnt<61 sets frame_err, clears word_cnt to 0 and stays in LOAD. The partial shadow is dead; it is overwritten by the next frame.
  - commit in LOAD is ignored.
- FULL state:
  - wr_ready=0.
  - On commit, or on a commit latched earlier in FULL (pending flag): if busy=0, copy shadow to data_reg in that cycle and go to FIRE. If busy=1, set pending and stay.
  - Pending clears on firing or on abort.
- FIRE state: trig=1 for exactly TRIG_LEN cycles starting the cycle after entry, then trig=0 and go to WAIT_START. data_reg is stable from one cycle before trig rises.
- WAIT_START state:
  - busy=1 goes to WAIT_DONE.
  - A timer counts from 0; reaching START_TIMEOUT-1 with busy still 0 sets timeout_err and goes to LOAD with word_cnt=0.
- WAIT_DONE state: first cycle with busy=0 pulses done for 1 cycle and goes to LOAD with word_cnt=0. data_reg holds its value.
- abort, any state: next cycle state=LOAD, word_cnt=0, trig=0, pending=0, timer=0. data_reg unchanged. abort has priority over every other event in the same cycle.
- Simultaneous wr_valid and commit in LOAD: the word is taken and commit is dropped.
- rst_n assertion mid-transfer: trig drops immediately (async), all state reset. The serializer's own strobe handles its side.
- Error flags are cleared only by reset.
- data_reg only ever changes on the FULL to FIRE transition, so it is never modified while busy=1.

Test Plan:
- Load 62 bytes 0x00..0x3D, then commit with busy=0 → data_reg[7:0]=0x00, data_reg[495-496 truncated: bits 490:488]=0x3D&0x7, trig high for 4 cycles, word_cnt=62 before commit.
- After trigger, drive busy high for 500 cycles then low → exactly one done pulse, state LOAD, word_cnt=0, data_reg unchanged.
- Send wr_last on word 10 → frame_err=1, word_cnt=0. Then a full 62-word frame loads normally.
- Commit while busy=1 held 20 cycles → no trig during busy. trig rises 2 cycles after busy falls (1 cycle to FIRE, pulse starts the cycle after entry) and lasts 4 cycles.
- Trigger with busy never asserted → timeout_err=1 at cycle 1024 after trig, state LOAD.
- Assert abort during FIRE, and separately rst_n low during WAIT_DONE → trig=0 next cycle (immediately for reset), word_cnt=0, no done pulse, data_reg retained on abort and zeroed on reset.
